top_ctrl_tiled: RTL
===================

Name: top_ctrl_tiled

Overview:
- Parametrised successor sequencer for multi-layer matrix-vector multiplication on the MAC tile array.
- Accepts runtime dimensions (rows, cols, layers) at start.
- Per layer, iterates row passes:
  - load pass (weights/inputs streamed, valid pipeline started);
  - readout pass (layer controller drains the selected accumulator bank).
- Adds a watchdog on sub-controller handshakes, abort, error reporting and a last-pass flag for the sub-controllers.

Parameters:
- MAX_N, 16, maximum rows/cols supported.
- ROWS_PER_PASS, 4, output rows produced per load pass (2 tiles x 2 MACs).
- NUM_ACC, 8, accumulator banks per MAC; acc_sel wraps modulo NUM_ACC.
- MAX_LAYERS, 4, maximum layers per run.
- TIMEOUT_CYC, 1024, watchdog limit in cycles for any WAIT state.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  run request, sampled in IDLE only
- abort  in  1  synchronous abort, any state
- cfg_rows  in  $clog2(MAX_N+1)  output rows this run
- cfg_cols  in  $clog2(MAX_N+1)  input length this run, forwarded as load_len
- cfg_layers  in  $clog2(MAX_LAYERS+1)  layers this run
- valid_ctrl_busy  in  1  load sub-controller busy level
- layer_ctrl_busy  in  1  readout sub-controller busy level
- row_pass  out  PASS_W  current pass index, PASS_W=max(1,$clog2(ceil(MAX_N/ROWS_PER_PASS)))
- layer_idx  out  $clog2(MAX_LAYERS)  current layer
- acc_sel  out  $clog2(NUM_ACC)  bank for both tiles
- load_len  out  $clog2(MAX_N+1)  latched cfg_cols
- last_pass  out  1  current pass is final pass of final layer
- mode  out  2  0 idle, 1 load, 2 layer, 3 error
- start_load  out  1  pulse to weight/input/valid controllers
- start_layer  out  1  pulse to layer controller
- busy  out  1  high from start accept until done/abort
- done  out  1  1-cycle completion pulse
- err_code  out  2  0 ok, 1 timeout, 2 bad cfg; held until next accepted start

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0.
- States and transitions:
  - IDLE: accept when start && !valid_ctrl_busy && !layer_ctrl_busy. On accept, latch cfg, clear err_code, set busy, go to CHECK.
  - CHECK: bad cfg (rows==0, cols==0, layers==0, rows>MAX_N, cols>MAX_N, layers>MAX_LAYERS) sets err_code=2, pulses done, goes to IDLE. Otherwise compute NPASS=ceil(rows/ROWS_PER_PASS) and go to ISSUE_LOAD.
  - ISSUE_LOAD: register start_load=1 (visible next cycle only), acc_sel=(layer_idx*NPASS+row_pass) mod NUM_ACC, mode=1, go to WAIT_LOAD_ON.
  - WAIT_LOAD_ON: wait for valid_ctrl_busy=1, then WAIT_LOAD_OFF.
  - WAIT_LOAD_OFF: wait for valid_ctrl_busy=0, then ISSUE_LAYER.
  - ISSUE_LAYER: start_layer 1-cycle pulse, mode=2, then WAIT_LAY_ON.
  - WAIT_LAY_ON / WAIT_LAY_OFF: same handshake on layer_ctrl_busy, then NEXT.
  - NEXT:
    - if row_pass<NPASS-1: row_pass++, go to ISSUE_LOAD;
    - else if layer_idx<layers-1: row_pass=0, layer_idx++, go to ISSUE_LOAD;
    - else: pulse done, clear busy, go to IDLE.
- Timing: start_load first visible 3 cycles after the start-accept edge (IDLE, CHECK, ISSUE_LOAD).
- Busy rising and falling in the same cycle is not detectable; sub-controllers must hold busy for at least 1 cycle.
- Watchdog counter resets on entry to each WAIT state and increments per WAIT cycle. At TIMEOUT_CYC:
  - err_code=1, mode=3 for one cycle;
  - done pulse, busy cleared, go to IDLE.
- Abort has priority over every transition, including the start accept. Next cycle: IDLE, busy=0, mode=0, pulses 0, no done, err_code unchanged.
- Outputs row_pass, layer_idx, acc_sel, last_pass, load_len are stable from ISSUE_LOAD through NEXT.
- start while busy is ignored.

Optional Feature:
- TOP_CTRL_PERF_EN defined: adds outputs perf_cycles[31:0] and perf_stall[31:0].
  - perf_cycles: cycles with busy=1.
  - perf_stall: cycles spent in WAIT_*_ON states.
  - Both clear on start accept and saturate at all-ones.
- Undefined: ports and counters are absent.

Decomposition:
- Package top_ctrl_pkg holds:
  - state enum;
  - mode codes MODE_IDLE/LOAD/LAYER/ERR;
  - err codes ERR_NONE/TIMEOUT/CFG;
  - ceil-div helper function.
- One sub-module, busy_handshake_wd: tracks busy-rise/fall with watchdog, and is instantiated once and shared across both handshakes via a select.

Test Plan:
- rows=4, cols=4, layers=1, busy 5 cycles each -> one start_load, one start_layer, acc_sel=0, last_pass=1, done, err_code=0.
- rows=10, cols=8, layers=2 -> NPASS=3, six load/layer pairs, acc_sel 0..5, row_pass 0,1,2,0,1,2, single done.
- rows=16, layers=3, NUM_ACC=8 -> 12 passes, acc_sel wraps to 0 at pass 8.
- valid_ctrl_busy never rises, TIMEOUT_CYC=16 -> done 16 cycles after WAIT_LOAD_ON entry, err_code=1, busy=0.
- rows=0 -> done 2 cycles after accept, err_code=2, no start_load.
- abort in WAIT_LAY_OFF -> IDLE next cycle, no done; new start then completes normally.

Source files
------------

// File: rtl/top_ctrl_pkg.sv
// Shared definitions for the tiled matrix-vector sequencer.
//   - state_e : sequencer FSM states
//   - MODE_*  : values driven on the mode output
//   - ERR_*   : values driven on the err_code output
//   - ceil_div: integer ceiling division, used for pass counts
package top_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE_LOAD,
    S_WAIT_LOAD_ON,
    S_WAIT_LOAD_OFF,
    S_ISSUE_LAYER,
    S_WAIT_LAY_ON,
    S_WAIT_LAY_OFF,
    S_NEXT
  } state_e;

  localparam logic [1:0] MODE_IDLE  = 2'd0;
  localparam logic [1:0] MODE_LOAD  = 2'd1;
  localparam logic [1:0] MODE_LAYER = 2'd2;
  localparam logic [1:0] MODE_ERR   = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_CFG     = 2'd2;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/top_ctrl_tiled_busy_handshake_wd.sv
// busy_handshake_wd: watches one of two sub-controller busy levels and
// reports the awaited edge, with a watchdog.
//   en      : a WAIT state is active
//   phase   : 0 = waiting for busy to rise, 1 = waiting for busy to fall
//   sel     : 0 = watch busy_a (load), 1 = watch busy_b (layer)
//   evt     : awaited level seen this cycle
//   timeout : TIMEOUT_CYC-th consecutive wait cycle without the event
// The counter is 0 in the first cycle of every wait, since it is cleared
// whenever the owner is not waiting or the awaited level has just arrived.
module busy_handshake_wd
  import top_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic phase,
  input  logic sel,
  input  logic busy_a,
  input  logic busy_b,
  output logic evt,
  output logic timeout
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic          busy_s;

  assign busy_s  = sel ? busy_b : busy_a;
  assign evt     = en && (phase ? !busy_s : busy_s);
  assign timeout = en && !evt && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        cnt_q <= '0;
    else if (!en || evt || timeout) cnt_q <= '0;
    else                            cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/top_ctrl_tiled.sv
// top_ctrl_tiled: multi-layer sequencer for the MAC tile array. For each
// layer it runs ceil(rows/ROWS_PER_PASS) passes, each a load handshake
// (start_load / valid_ctrl_busy) followed by a readout handshake
// (start_layer / layer_ctrl_busy).
// Inputs : start, abort, cfg_rows/cols/layers, valid_ctrl_busy, layer_ctrl_busy
// Outputs: row_pass, layer_idx, acc_sel, load_len, last_pass, mode,
//          start_load, start_layer, busy, done, err_code
// Optional: define TOP_CTRL_PERF_EN to add perf_cycles / perf_stall.
// All outputs are registered.
module top_ctrl_tiled
  import top_ctrl_pkg::*;
#(
  parameter int MAX_N         = 16,
  parameter int ROWS_PER_PASS = 4,
  parameter int NUM_ACC       = 8,
  parameter int MAX_LAYERS    = 4,
  parameter int TIMEOUT_CYC   = 1024,
  localparam int NPASS_MAX = ceil_div(MAX_N, ROWS_PER_PASS),
  localparam int PASS_W    = (NPASS_MAX > 1) ? $clog2(NPASS_MAX) : 1,
  localparam int NP_W      = $clog2(NPASS_MAX + 1),
  localparam int RW        = $clog2(MAX_N + 1),
  localparam int LW        = $clog2(MAX_LAYERS + 1),
  localparam int LI_W      = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1,
  localparam int AW        = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [RW-1:0]     cfg_rows,
  input  logic [RW-1:0]     cfg_cols,
  input  logic [LW-1:0]     cfg_layers,
  input  logic              valid_ctrl_busy,
  input  logic              layer_ctrl_busy,
  output logic [PASS_W-1:0] row_pass,
  output logic [LI_W-1:0]   layer_idx,
  output logic [AW-1:0]     acc_sel,
  output logic [RW-1:0]     load_len,
  output logic              last_pass,
  output logic [1:0]        mode,
  output logic              start_load,
  output logic              start_layer,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code
`ifdef TOP_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stall
`endif
);

  state_e            state_q, state_n;
  logic [RW-1:0]     rows_q, rows_n, load_len_n;
  logic [LW-1:0]     layers_q, layers_n;
  logic [NP_W-1:0]   npass_q, npass_n, npass_calc;
  logic [PASS_W-1:0] row_pass_n;
  logic [LI_W-1:0]   layer_idx_n;
  logic [AW-1:0]     acc_sel_n;
  logic              last_pass_n, start_load_n, start_layer_n, busy_n, done_n;
  logic [1:0]        mode_n, err_n;
  logic              accept, cfg_bad, adv;
  logic              wd_en, wd_evt, wd_to;

  assign accept = (state_q == S_IDLE) && start && !valid_ctrl_busy &&
                  !layer_ctrl_busy && !abort;

  assign cfg_bad = (rows_q == '0) || (load_len == '0) || (layers_q == '0) ||
                   (rows_q > RW'(MAX_N)) || (load_len > RW'(MAX_N)) ||
                   (layers_q > LW'(MAX_LAYERS));

  assign npass_calc = NP_W'(ceil_div(int'(rows_q), ROWS_PER_PASS));

  assign wd_en = (state_q == S_WAIT_LOAD_ON) || (state_q == S_WAIT_LOAD_OFF) ||
                 (state_q == S_WAIT_LAY_ON)  || (state_q == S_WAIT_LAY_OFF);

  busy_handshake_wd #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .en      (wd_en),
    .phase   ((state_q == S_WAIT_LOAD_OFF) || (state_q == S_WAIT_LAY_OFF)),
    .sel     ((state_q == S_WAIT_LAY_ON) || (state_q == S_WAIT_LAY_OFF)),
    .busy_a  (valid_ctrl_busy),
    .busy_b  (layer_ctrl_busy),
    .evt     (wd_evt),
    .timeout (wd_to)
  );

  always_comb begin
    state_n       = state_q;
    rows_n        = rows_q;
    layers_n      = layers_q;
    load_len_n    = load_len;
    npass_n       = npass_q;
    row_pass_n    = row_pass;
    layer_idx_n   = layer_idx;
    acc_sel_n     = acc_sel;
    last_pass_n   = last_pass;
    mode_n        = mode;
    err_n         = err_code;
    busy_n        = busy;
    start_load_n  = 1'b0;
    start_layer_n = 1'b0;
    done_n        = 1'b0;
    adv           = 1'b0;
    if (abort) begin
      state_n = S_IDLE;
      busy_n  = 1'b0;
      mode_n  = MODE_IDLE;
    end else if (wd_to) begin
      state_n = S_IDLE;
      err_n   = ERR_TIMEOUT;
      mode_n  = MODE_ERR;
      done_n  = 1'b1;
      busy_n  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          mode_n = MODE_IDLE;  // drops MODE_ERR after its single cycle
          if (accept) begin
            rows_n     = cfg_rows;
            load_len_n = cfg_cols;
            layers_n   = cfg_layers;
            err_n      = ERR_NONE;
            busy_n     = 1'b1;
            state_n    = S_CHECK;
          end
        end
        S_CHECK: begin
          if (cfg_bad) begin
            err_n   = ERR_CFG;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = S_IDLE;
          end else begin
            npass_n     = npass_calc;
            row_pass_n  = '0;
            layer_idx_n = '0;
            acc_sel_n   = '0;
            last_pass_n = (npass_calc == NP_W'(1)) && (layers_q == LW'(1));
            state_n     = S_ISSUE_LOAD;
          end
        end
        S_ISSUE_LOAD: begin
          start_load_n = 1'b1;
          mode_n       = MODE_LOAD;
          state_n      = S_WAIT_LOAD_ON;
        end
        S_WAIT_LOAD_ON:  if (wd_evt) state_n = S_WAIT_LOAD_OFF;
        S_WAIT_LOAD_OFF: if (wd_evt) state_n = S_ISSUE_LAYER;
        S_ISSUE_LAYER: begin
          start_layer_n = 1'b1;
          mode_n        = MODE_LAYER;
          state_n       = S_WAIT_LAY_ON;
        end
        S_WAIT_LAY_ON:   if (wd_evt) state_n = S_WAIT_LAY_OFF;
        S_WAIT_LAY_OFF:  if (wd_evt) state_n = S_NEXT;
        S_NEXT: begin
          if (NP_W'(row_pass) < npass_q - NP_W'(1)) begin
            row_pass_n = row_pass + PASS_W'(1);
            adv        = 1'b1;
          end else if (LW'(layer_idx) < layers_q - LW'(1)) begin
            row_pass_n  = '0;
            layer_idx_n = layer_idx + LI_W'(1);
            adv         = 1'b1;
          end else begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            mode_n  = MODE_IDLE;
            state_n = S_IDLE;
          end
          // acc_sel tracks the linear pass index layer*NPASS+row_pass mod
          // NUM_ACC; a wrapping increment avoids the multiplier.
          if (adv) begin
            acc_sel_n   = (acc_sel == AW'(NUM_ACC - 1)) ? '0 : acc_sel + AW'(1);
            last_pass_n = (NP_W'(row_pass_n) == npass_q - NP_W'(1)) &&
                          (LW'(layer_idx_n) == layers_q - LW'(1));
            state_n     = S_ISSUE_LOAD;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rows_q      <= '0;
      layers_q    <= '0;
      npass_q     <= '0;
      load_len    <= '0;
      row_pass    <= '0;
      layer_idx   <= '0;
      acc_sel     <= '0;
      last_pass   <= 1'b0;
      mode        <= MODE_IDLE;
      err_code    <= ERR_NONE;
      busy        <= 1'b0;
      start_load  <= 1'b0;
      start_layer <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_n;
      rows_q      <= rows_n;
      layers_q    <= layers_n;
      npass_q     <= npass_n;
      load_len    <= load_len_n;
      row_pass    <= row_pass_n;
      layer_idx   <= layer_idx_n;
      acc_sel     <= acc_sel_n;
      last_pass   <= last_pass_n;
      mode        <= mode_n;
      err_code    <= err_n;
      busy        <= busy_n;
      start_load  <= start_load_n;
      start_layer <= start_layer_n;
      done        <= done_n;
    end
  end

`ifdef TOP_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy && !(&perf_cycles)) perf_cycles <= perf_cycles + 32'd1;
      if (((state_q == S_WAIT_LOAD_ON) || (state_q == S_WAIT_LAY_ON)) &&
          !(&perf_stall))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
